// File: rtl/la_sample_pkg.sv
// Shared sample-buffer constants, packet layout and address helpers.
// Used by both the capture packet writer and the readback engine.
package la_sample_pkg;

    localparam int SAMPLE_WIDTH             = 16;
    localparam int SAMPLE_PACKET_WIDTH      = 32;
    localparam int MEMORY_CAPACITY          = 2 ** 27;
    localparam int MEMORY_WORD_WIDTH        = 2;
    localparam int TRANSITION_COUNTER_WIDTH = SAMPLE_PACKET_WIDTH - SAMPLE_WIDTH;
    localparam int NUM_BYTES_PER_PACKET     = SAMPLE_PACKET_WIDTH / 8;
    localparam int NUM_WORDS_PER_PACKET     = NUM_BYTES_PER_PACKET / MEMORY_WORD_WIDTH;
    localparam logic [31:0] MAX_SAMPLE_NUMBER =
        32'(MEMORY_CAPACITY / MEMORY_WORD_WIDTH / NUM_WORDS_PER_PACKET - 1);

    typedef struct packed {
        logic [TRANSITION_COUNTER_WIDTH-1:0] interval;
        logic [SAMPLE_WIDTH-1:0]             data;
    } sample_packet_t;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_FETCH,
        RB_DRAIN,
        RB_DONE
    } rb_state_t;

    // The sample buffer is circular: the address after the last packet is 0.
    function automatic logic [31:0] wrap_inc(input logic [31:0] n);
        return (n == MAX_SAMPLE_NUMBER) ? 32'd0 : n + 32'd1;
    endfunction

endpackage

// File: rtl/sample_readback_if.sv
// Memory read port plus decoded-sample stream of the readback engine.
// The master modport is the readback engine side.
interface sample_readback_if;
    import la_sample_pkg::*;

    logic                                rd_req;
    logic [31:0]                         rd_sample_number;
    logic                                rd_ack;
    logic                                rd_valid;
    logic [SAMPLE_PACKET_WIDTH-1:0]      rd_data;
    logic                                out_valid;
    logic                                out_ready;
    logic [SAMPLE_WIDTH-1:0]             out_data;
    logic [TRANSITION_COUNTER_WIDTH-1:0] out_interval;
    logic                                out_last;

    modport master (
        output rd_req, rd_sample_number, out_valid, out_data, out_interval, out_last,
        input  rd_ack, rd_valid, rd_data, out_ready
    );

    modport slave (
        input  rd_req, rd_sample_number, out_valid, out_data, out_interval, out_last,
        output rd_ack, rd_valid, rd_data, out_ready
    );

endinterface

// File: rtl/sample_readback_fifo.sv
// Synchronous response FIFO with occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_readback_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];
    assign count   = count_q;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) rd_d = rd_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Upstream credit accounting must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(push && full && !do_pop));
    end

endmodule

// File: rtl/sample_readback.sv
// Walks the circular sample buffer from begin to end and streams decoded samples.
// SAMPLE_READBACK_EXPAND_EN enables run-length expansion of the interval field.
//   state | meaning
//   IDLE  | waiting for start (and for late responses of an aborted run)
//   FETCH | issuing reads while FIFO + outstanding has room
//   DRAIN | all reads issued, streaming out the remaining beats
//   DONE  | one-cycle done pulse
module sample_readback
    import la_sample_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       sampleNum_Begin_pa,
    input  logic [31:0]       sampleNum_End_pa,
    sample_readback_if.master bus,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    rb_state_t      state_q, state_d;
    logic [31:0]    addr_q, addr_d, end_q, end_d, total_q, total_d, pkt_q, pkt_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic [SAMPLE_PACKET_WIDTH-1:0] fifo_head;
    sample_packet_t head;
    logic           push, pop, flush, acked, resp_in, handshake, own_beat, last_beat, credit_ok;

    sample_readback_fifo #(.WIDTH(SAMPLE_PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.rd_data),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign head      = fifo_head;
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_C;
    assign bus.rd_req           = (state_q == RB_FETCH) && credit_ok && !abort;
    assign bus.rd_sample_number = addr_q;
    assign acked     = bus.rd_req && bus.rd_ack;
    assign resp_in   = bus.rd_valid && (outst_q != '0);
    // Responses belonging to an aborted run are counted but never stored.
    assign push      = resp_in && ((state_q == RB_FETCH) || (state_q == RB_DRAIN)) && !abort;
    assign bus.out_valid = !fifo_empty;
    assign handshake = bus.out_valid && bus.out_ready;
    assign pop       = handshake && own_beat;
    assign last_beat = bus.out_valid && own_beat && (pkt_q == total_q - 32'd1);
    assign bus.out_last = last_beat;
    assign busy      = (state_q != RB_IDLE);
    assign done      = (state_q == RB_DONE);

`ifdef SAMPLE_READBACK_EXPAND_EN
    logic [SAMPLE_WIDTH-1:0]             prev_q, prev_d;
    logic [TRANSITION_COUNTER_WIDTH-1:0] rep_q, rep_d;

    always_comb begin
        prev_d = prev_q;
        rep_d  = rep_q;
        own_beat = (pkt_q == 32'd0) || (rep_q == head.interval);
        bus.out_data     = own_beat ? head.data : prev_q;
        bus.out_interval = '0;
        if (flush) begin
            rep_d = '0;
        end else if (handshake) begin
            if (own_beat) begin
                rep_d  = '0;
                prev_d = head.data;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            rep_q  <= '0;
        end else begin
            prev_q <= prev_d;
            rep_q  <= rep_d;
        end
    end
`else
    always_comb begin
        own_beat         = 1'b1;
        bus.out_data     = head.data;
        bus.out_interval = head.interval;
    end
`endif

    always_comb begin
        outst_d = outst_q;
        if (acked && !resp_in)      outst_d = outst_q + 1'b1;
        else if (!acked && resp_in) outst_d = outst_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        total_d = total_q;
        pkt_d   = pkt_q;
        flush   = 1'b0;
        if (pop)   pkt_d  = pkt_q + 32'd1;
        if (acked) addr_d = wrap_inc(addr_q);
        case (state_q)
            RB_IDLE: begin
                if (start && (outst_q == '0)) begin
                    state_d = RB_FETCH;
                    addr_d  = sampleNum_Begin_pa;
                    end_d   = sampleNum_End_pa;
                    pkt_d   = 32'd0;
                    total_d = (sampleNum_End_pa >= sampleNum_Begin_pa)
                            ? sampleNum_End_pa - sampleNum_Begin_pa + 32'd1
                            : MAX_SAMPLE_NUMBER - sampleNum_Begin_pa + sampleNum_End_pa + 32'd2;
                end
            end
            RB_FETCH: if (acked && (addr_q == end_q)) state_d = RB_DRAIN;
            RB_DRAIN: if (handshake && last_beat)     state_d = RB_DONE;
            RB_DONE:  state_d = RB_IDLE;
            default:  state_d = RB_IDLE;
        endcase
        if (abort) begin
            state_d = RB_IDLE;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RB_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            total_q <= '0;
            pkt_q   <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            total_q <= total_d;
            pkt_q   <= pkt_d;
            outst_q <= outst_d;
        end
    end

endmodule
